fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the PC and issues req/ack-handshaked reads to instruction memory.
- Presents a stable 32-bit instruction plus PC/PC+4 to decode and execute.
- When an instruction retires, advances to PC+4 or to the resolved branch/jump target. An instruction flagged invalid by the decoder halts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low two bits must be 0.
- ADDR_W, 32, PC and memory address width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- o_imem_req  out  1  fetch request to instruction memory.
- o_imem_addr  out  ADDR_W  word-aligned fetch address (= PC).
- i_imem_ack  in  1  memory returns data this cycle; valid only while o_imem_req=1.
- i_imem_rdata  in  32  instruction word, sampled when o_imem_req & i_imem_ack.
- o_instruction  out  32  held instruction to decoder.
- o_pc  out  ADDR_W  PC of o_instruction.
- o_pc_four  out  ADDR_W  o_pc + 4, modulo 2^ADDR_W.
- o_insn_valid  out  1  o_instruction/o_pc are valid.
- i_insn_ready  in  1  downstream retires the held instruction this cycle.
- i_pc_sel  in  1  decoder's taken-branch/jump select for the held instruction.
- i_alu_data  in  ADDR_W  branch/jump target from ALU.
- i_insn_vld  in  1  decoder reports the held instruction as legal.
- o_halt  out  1  fetch stopped on an illegal instruction.
- o_retire_cnt  out  32  count of retired instructions.

Behaviour:
- FSM states:
  - S_REQ: o_imem_req=1, o_insn_valid=0.
  - S_HOLD: o_imem_req=0, o_insn_valid=1.
  - S_HALT: o_imem_req=0, o_insn_valid=0, o_halt=1.
- Reset (i_reset=1 at an edge), applied from any state including mid-request:
  - state<=S_REQ, pc<=RESET_PC, o_instruction<=0, o_retire_cnt<=0.
  - Outstanding memory request is abandoned. Memory shares i_reset and must drop it.
  - During the reset cycle o_imem_req=0 and o_insn_valid=0.
- First cycle after reset release: o_imem_req=1, o_imem_addr=RESET_PC.
- S_REQ:
  - o_imem_addr=pc, held stable until ack.
  - On i_imem_ack=1: capture i_imem_rdata into o_instruction, go to S_HOLD next cycle.
  - Zero-wait ack (same cycle as req) is legal. No timeout.
- S_HOLD: o_instruction, o_pc, o_pc_four held constant.
  - If i_insn_vld=0: go to S_HALT (takes priority over i_insn_ready). No retire, no count.
  - Else if i_insn_ready=1 (retire):
    - pc <= i_pc_sel ? {i_alu_data[ADDR_W-1:2],2'b00} : pc+4.
    - o_retire_cnt += 1, wrapping at 2^32.
    - Go to S_REQ.
  - Else: stay in S_HOLD.
- i_pc_sel and i_alu_data are sampled only on the retire edge and ignored otherwise.
- i_imem_ack is ignored outside S_REQ.
- S_HALT: absorbing state; only i_reset exits.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000. o_pc_four wraps the same way.
- Throughput: with zero-wait memory and i_insn_ready tied high, one retire per 2 cycles.
- Latency: from ack, o_insn_valid rises 1 cycle later.
- o_pc_four is combinational from the pc register. All other outputs are decoded from registered state/regs with no input-to-output combinational path, except o_imem_addr=pc.

Test Plan:
- Reset, then zero-wait memory, ready=1, pc_sel=0, insn_vld=1 → addresses 0x0,0x4,0x8,0xC on req cycles 1,3,5,7; o_retire_cnt=4 after the 4th retire.
- Memory ack delayed 3 cycles at addr 0x4 → o_imem_addr stays 0x4 and req stays 1 for 4 cycles; o_insn_valid rises the cycle after ack with the rdata captured.
- Hold instruction with ready=0 for 5 cycles, toggling i_pc_sel/i_alu_data → outputs stable, no request; then ready=1 with pc_sel=1, alu_data=0x0000_0103 → next o_imem_addr=0x0000_0100.
- i_insn_vld=0 while ready=1 at pc=0x8 → o_halt=1 next cycle, no further req, count unchanged; assert reset → fetch restarts at RESET_PC with count 0.
- Reset asserted while in S_REQ waiting for ack at 0x10 → req drops during reset; after release req at RESET_PC; the stale ack is not captured.
- pc=0xFFFF_FFFC retire with pc_sel=0 → next o_imem_addr=0x0000_0000 and o_pc_four=0x0000_0000 while held at 0xFFFF_FFFC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack memory port and
// presents the held instruction plus PC/PC+4 to decode until it retires.
module fetch_unit #(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [31:0]       i_imem_rdata,
    output logic [31:0]       o_instruction,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_four,
    output logic              o_insn_valid,
    input  logic              i_insn_ready,
    input  logic              i_pc_sel,
    input  logic [ADDR_W-1:0] i_alu_data,
    input  logic              i_insn_vld,
    output logic              o_halt,
    output logic [31:0]       o_retire_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              rst_q;

    // rst_q keeps the request low for the cycle that follows a reset edge.
    always_ff @(posedge i_clk) begin
        rst_q <= i_reset;
        if (i_reset) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            o_instruction <= '0;
            o_retire_cnt  <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (!rst_q && i_imem_ack) begin
                        o_instruction <= i_imem_rdata;
                        state         <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // An illegal instruction halts before any retire is considered.
                    if (!i_insn_vld) begin
                        state <= S_HALT;
                    end else if (i_insn_ready) begin
                        pc           <= i_pc_sel ? (i_alu_data & ~ADDR_W'(3))
                                                 : pc + ADDR_W'(4);
                        o_retire_cnt <= o_retire_cnt + 32'd1;
                        state        <= S_REQ;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    assign o_imem_req   = (state == S_REQ) && !rst_q;
    assign o_imem_addr  = pc;
    assign o_pc         = pc;
    assign o_pc_four    = pc + ADDR_W'(4);
    assign o_insn_valid = (state == S_HOLD);
    assign o_halt       = (state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// PC/count reference model kept at instruction granularity.
module tb_fetch_unit;

    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] RPC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   instruction;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_four;
    logic          insn_valid;
    logic          insn_ready;
    logic          pc_sel;
    logic [AW-1:0] alu_data;
    logic          insn_vld;
    logic          halt;
    logic [31:0]   retire_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .i_clk(clk), .i_reset(reset),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .o_instruction(instruction), .o_pc(pc), .o_pc_four(pc_four),
        .o_insn_valid(insn_valid), .i_insn_ready(insn_ready),
        .i_pc_sel(pc_sel), .i_alu_data(alu_data), .i_insn_vld(insn_vld),
        .o_halt(halt), .o_retire_cnt(retire_cnt)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ack = 1'b0; insn_ready = 1'b0; pc_sel = 1'b0; insn_vld = 1'b1;
        step();
        reset = 1'b0;
        step();
        cyc = 1;
    endtask

    // Plain fetch at the current address with zero-wait ack, then retire sequentially.
    task automatic fetch_retire(input logic [31:0] word);
        imem_ack = 1'b1; imem_rdata = word;
        step();
        imem_ack = 1'b0; insn_ready = 1'b1; pc_sel = 1'b0;
        step();
        insn_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ack = 1'b0; insn_ready = 1'b0; pc_sel = 1'b0;
        insn_vld = 1'b1; alu_data = '0; imem_rdata = '0;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", insn_valid); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", halt); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_insn got %h want 0", instruction); end
        checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %0d want 0", retire_cnt); end
        checks++; if (pc !== RPC) begin errors++; $display("FAIL reset_pc got %h want %h", pc, RPC); end
        reset = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin errors++;
            $display("FAIL release_req got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RPC); end
    endtask

    task automatic test_sequential();
        logic [31:0] w;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || cyc != 2 * k + 1) begin errors++;
                $display("FAIL seq_req[%0d] got req=%b addr=%h cyc=%0d want req=1 addr=%h cyc=%0d",
                         k, imem_req, imem_addr, cyc, 32'(4 * k), 2 * k + 1); end
            w = $urandom; imem_ack = 1'b1; imem_rdata = w;
            step();
            imem_ack = 1'b0;
            checks++; if (insn_valid !== 1'b1 || instruction !== w || pc !== 32'(4 * k)) begin errors++;
                $display("FAIL seq_hold[%0d] got v=%b insn=%h pc=%h want v=1 insn=%h pc=%h",
                         k, insn_valid, instruction, pc, w, 32'(4 * k)); end
            insn_ready = 1'b1;
            step();
            insn_ready = 1'b0;
        end
        checks++; if (retire_cnt !== 32'd4) begin errors++; $display("FAIL seq_cnt got %0d want 4", retire_cnt); end
    endtask

    task automatic test_ack_delay();
        logic [31:0] w;
        do_reset();
        fetch_retire($urandom);
        w = $urandom;
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || insn_valid !== 1'b0) begin errors++;
                $display("FAIL delay_wait[%0d] got req=%b addr=%h v=%b want req=1 addr=4 v=0",
                         i, imem_req, imem_addr, insn_valid); end
            imem_ack = (i == 3); imem_rdata = (i == 3) ? w : ~w;
            step();
        end
        imem_ack = 1'b0;
        checks++; if (insn_valid !== 1'b1 || instruction !== w || imem_req !== 1'b0) begin errors++;
            $display("FAIL delay_capture got v=%b insn=%h req=%b want v=1 insn=%h req=0",
                     insn_valid, instruction, imem_req, w); end
    endtask

    // Continues from test_ack_delay with the instruction at 0x4 held.
    task automatic test_hold_stall();
        logic [31:0] held;
        held = instruction;
        for (int i = 0; i < 5; i++) begin
            insn_ready = 1'b0; pc_sel = 1'($urandom); alu_data = $urandom;
            imem_ack = 1'($urandom); imem_rdata = $urandom;
            step();
            checks++; if (imem_req !== 1'b0 || insn_valid !== 1'b1 || instruction !== held ||
                          pc !== 32'h4 || pc_four !== 32'h8 || retire_cnt !== 32'd1) begin errors++;
                $display("FAIL stall[%0d] got req=%b v=%b insn=%h pc=%h pc4=%h cnt=%0d want req=0 v=1 insn=%h pc=4 pc4=8 cnt=1",
                         i, imem_req, insn_valid, instruction, pc, pc_four, retire_cnt, held); end
        end
        imem_ack = 1'b0; insn_ready = 1'b1; pc_sel = 1'b1; alu_data = 32'h0000_0103;
        step();
        insn_ready = 1'b0; pc_sel = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || retire_cnt !== 32'd2) begin errors++;
            $display("FAIL branch got req=%b addr=%h cnt=%0d want req=1 addr=100 cnt=2",
                     imem_req, imem_addr, retire_cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        fetch_retire($urandom);
        fetch_retire($urandom);
        imem_ack = 1'b1; imem_rdata = $urandom;
        step();
        imem_ack = 1'b0; insn_vld = 1'b0; insn_ready = 1'b1;
        checks++; if (pc !== 32'h8 || insn_valid !== 1'b1) begin errors++;
            $display("FAIL halt_pre got pc=%h v=%b want pc=8 v=1", pc, insn_valid); end
        step();
        insn_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (halt !== 1'b1 || imem_req !== 1'b0 || insn_valid !== 1'b0 || retire_cnt !== 32'd2) begin errors++;
                $display("FAIL halt[%0d] got halt=%b req=%b v=%b cnt=%0d want halt=1 req=0 v=0 cnt=2",
                         i, halt, imem_req, insn_valid, retire_cnt); end
            imem_ack = 1'($urandom); insn_ready = 1'($urandom);
            step();
        end
        imem_ack = 1'b0; insn_ready = 1'b0;
        do_reset();
        checks++; if (halt !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC || retire_cnt !== 32'd0) begin errors++;
            $display("FAIL halt_restart got halt=%b req=%b addr=%h cnt=%0d want halt=0 req=1 addr=%h cnt=0",
                     halt, imem_req, imem_addr, retire_cnt, RPC); end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        for (int k = 0; k < 4; k++) fetch_retire($urandom);
        for (int i = 0; i < 2; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++;
                $display("FAIL midreq_wait got req=%b addr=%h want req=1 addr=10", imem_req, imem_addr); end
            step();
        end
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        checks++; if (imem_req !== 1'b0 || insn_valid !== 1'b0) begin errors++;
            $display("FAIL midreq_reset got req=%b v=%b want 0 0", imem_req, insn_valid); end
        reset = 1'b0;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== RPC || instruction !== 32'h0 || insn_valid !== 1'b0) begin errors++;
                $display("FAIL midreq_stale[%0d] got req=%b addr=%h insn=%h v=%b want req=1 addr=%h insn=0 v=0",
                         i, imem_req, imem_addr, instruction, insn_valid, RPC); end
            step();
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        imem_ack = 1'b1; imem_rdata = $urandom;
        step();
        imem_ack = 1'b0; insn_ready = 1'b1; pc_sel = 1'b1; alu_data = 32'hFFFF_FFFF;
        step();
        insn_ready = 1'b0; pc_sel = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++;
            $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC || pc_four !== 32'h0) begin errors++;
            $display("FAIL wrap_hold got pc=%h pc4=%h want fffffffc 0", pc, pc_four); end
        insn_ready = 1'b1;
        step();
        insn_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++;
            $display("FAIL wrap_next got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    endtask

    // Random latency, stalls and branches against an instruction-level model.
    task automatic test_random();
        logic [31:0] mpc, mcnt, w;
        int lat, stall;
        do_reset();
        mpc = RPC; mcnt = 0;
        for (int n = 0; n < 150; n++) begin
            lat = $urandom_range(0, 3);
            w = $urandom;
            for (int i = 0; i <= lat; i++) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== mpc || insn_valid !== 1'b0) begin errors++;
                    $display("FAIL rnd_req[%0d] got req=%b addr=%h v=%b want req=1 addr=%h v=0",
                             n, imem_req, imem_addr, insn_valid, mpc); end
                imem_ack = (i == lat); imem_rdata = (i == lat) ? w : $urandom;
                pc_sel = 1'($urandom); alu_data = $urandom;
                step();
            end
            stall = $urandom_range(0, 3);
            for (int i = 0; i <= stall; i++) begin
                checks++; if (insn_valid !== 1'b1 || imem_req !== 1'b0 || instruction !== w ||
                              pc !== mpc || pc_four !== mpc + 32'd4 || retire_cnt !== mcnt) begin errors++;
                    $display("FAIL rnd_hold[%0d] got v=%b req=%b insn=%h pc=%h pc4=%h cnt=%0d want v=1 req=0 insn=%h pc=%h pc4=%h cnt=%0d",
                             n, insn_valid, imem_req, instruction, pc, pc_four, retire_cnt, w, mpc, mpc + 32'd4, mcnt); end
                imem_ack = 1'($urandom); imem_rdata = $urandom;
                pc_sel = 1'($urandom); alu_data = $urandom;
                insn_ready = (i == stall);
                if (i == stall) mpc = pc_sel ? {alu_data[31:2], 2'b00} : mpc + 32'd4;
                step();
            end
            insn_ready = 1'b0; imem_ack = 1'b0;
            mcnt++;
        end
        checks++; if (retire_cnt !== mcnt) begin errors++;
            $display("FAIL rnd_cnt got %0d want %0d", retire_cnt, mcnt); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ack_delay();
        test_hold_stall();
        test_halt();
        test_reset_mid_req();
        test_pc_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
